writeback_unit: RTL and testbench

Buffered write-back stage sitting directly downstream of `ALU_unit` and upstream of the write port of `reg_bank`. It accepts completed results (destination register address plus 32-bit data) from the execute stage, queues them in a small in-order FIFO, and retires at most one register write per clock. It absorbs register-file back-pressure (`stall`), supports a pipeline `flush`, and can optionally supply bypass data for source operands whose producers have not yet been written back.

---
 rtl/writeback_unit.sv | 117 +++++++++++
 tb/tb_writeback_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// In-order write-back FIFO between the execute stage and the register-bank write port.
// Define WB_FORWARD_EN to build the operand bypass compare logic; otherwise fwd_* outputs are tied to 0.
module writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic                       ex_we,
  input  logic [ADDR_W-1:0]          ex_rd_addr,
  input  logic [DATA_W-1:0]          ex_rd_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       wb_en,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  input  logic [ADDR_W-1:0]          fwd_rs1_addr,
  input  logic [ADDR_W-1:0]          fwd_rs2_addr,
  output logic                       fwd_rs1_hit,
  output logic                       fwd_rs2_hit,
  output logic [DATA_W-1:0]          fwd_rs1_data,
  output logic [DATA_W-1:0]          fwd_rs2_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              enq;
  logic              deq;

  // Ready looks only at the registered count: no pass-through when full.
  assign ex_ready = (count < CNT_W'(DEPTH));
  assign enq      = ex_valid & ex_ready & ex_we & ~flush;
  assign deq      = (count != '0) & ~stall & ~flush;
  assign pending  = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      wb_en <= 1'b0;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          mem_addr[tail] <= ex_rd_addr;
          mem_data[tail] <= ex_rd_data;
          tail           <= tail + 1'b1;
        end
        // Output register: wb_addr/wb_data hold their last value when no write retires.
        if (deq) begin
          wb_en   <= 1'b1;
          wb_addr <= mem_addr[head];
          wb_data <= mem_data[head];
          head    <= head + 1'b1;
        end
        if (enq && !deq) begin
          count <= count + 1'b1;
        end else if (!enq && deq) begin
          count <= count - 1'b1;
        end
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Walk from oldest to youngest so a younger match overrides; the output register is weakest.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0]  r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (wb_en && (wb_addr == addr)) begin
      r = {1'b1, wb_data};
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem_addr[idx] == addr)) begin
        r = {1'b1, mem_data[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_rs1_hit, fwd_rs1_data} = fwd_lookup(fwd_rs1_addr);
    {fwd_rs2_hit, fwd_rs2_data} = fwd_lookup(fwd_rs2_addr);
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^{fwd_rs1_addr, fwd_rs2_addr};
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: cycle vector table, write-order scoreboard and reset-mid-drain sequence.
module tb_writeback_unit;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_we;
  logic [ADDR_W-1:0] ex_rd_addr;
  logic [DATA_W-1:0] ex_rd_data;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        pending;
  logic [ADDR_W-1:0] fwd_rs1_addr;
  logic [ADDR_W-1:0] fwd_rs2_addr;
  logic              fwd_rs1_hit;
  logic              fwd_rs2_hit;
  logic [DATA_W-1:0] fwd_rs1_data;
  logic [DATA_W-1:0] fwd_rs2_data;

  writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we),
    .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pending(pending),
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: results pushed when the bench's own occupancy model says they are accepted.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t sb[$];
  int  tb_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      tb_cnt <= 0;
    end else if (flush) begin
      sb.delete();
      tb_cnt <= 0;
    end else begin
      if (ex_valid && ex_we && (tb_cnt < DEPTH)) begin
        sb.push_back('{a: ex_rd_addr, d: ex_rd_data});
        tb_cnt <= tb_cnt + 1 - ((tb_cnt > 0 && !stall) ? 1 : 0);
      end else begin
        tb_cnt <= tb_cnt - ((tb_cnt > 0 && !stall) ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("mon_ready", 32'(ex_ready), (tb_cnt < DEPTH) ? 32'd1 : 32'd0);
      check("mon_pending", 32'(pending), 32'(tb_cnt));
      if (wb_en) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_write: got addr 0x%0h data 0x%0h, required no write", wb_addr, wb_data);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("sb_addr", 32'(wb_addr), 32'(e.a));
          check("sb_data", wb_data, e.d);
        end
      end
    end
  end

  typedef struct {
    int v, we, a, d, st, fl, rs1, rs2;
    int rdy, pend, en, wa, wd, h1, d1, h2, d2;
  } vec_t;
  vec_t tbl[26];

  task automatic drive(input int v, input int we, input int a, input int d, input int st, input int fl);
    ex_valid   = v[0];
    ex_we      = we[0];
    ex_rd_addr = ADDR_W'(a);
    ex_rd_data = d;
    stall      = st[0];
    flush      = fl[0];
  endtask

  task automatic check_fwd(input string tag, input int h1, input int d1, input int h2, input int d2);
    check({tag, "_h1"}, 32'(fwd_rs1_hit), FWD ? 32'(h1) : 32'd0);
    check({tag, "_h2"}, 32'(fwd_rs2_hit), FWD ? 32'(h2) : 32'd0);
    if (FWD && h1 != 0) check({tag, "_d1"}, fwd_rs1_data, d1);
    if (FWD && h2 != 0) check({tag, "_d2"}, fwd_rs2_data, d2);
    if (!FWD) begin
      check({tag, "_d1z"}, fwd_rs1_data, 32'd0);
      check({tag, "_d2z"}, fwd_rs2_data, 32'd0);
    end
  endtask

  initial begin
    //           v we  a  d            st fl rs1 rs2  rdy pend en wa wd        h1 d1           h2 d2
    tbl[0]  = '{1, 1, 2, 'h1B,        0, 0,  2,  0,  1, 1, 0, 0, 0,           1, 'h1B,        0, 0};
    tbl[1]  = '{0, 0, 0, 0,           0, 0,  2,  0,  1, 0, 1, 2, 'h1B,        1, 'h1B,        0, 0};
    tbl[2]  = '{0, 0, 0, 0,           0, 0,  2,  0,  1, 0, 0, 2, 'h1B,        0, 0,           0, 0};
    tbl[3]  = '{1, 0, 5, 'h55,        0, 0,  5, 31,  1, 0, 0, 2, 'h1B,        0, 0,           0, 0};
    tbl[4]  = '{0, 0, 0, 0,           0, 0,  5, 31,  1, 0, 0, 2, 'h1B,        0, 0,           0, 0};
    tbl[5]  = '{1, 1, 3, 3,           1, 0,  3, 31,  1, 1, 0, 2, 'h1B,        1, 3,           0, 0};
    tbl[6]  = '{1, 1, 4, 4,           1, 0,  3,  4,  1, 2, 0, 2, 'h1B,        1, 3,           1, 4};
    tbl[7]  = '{1, 1, 5, 5,           1, 0,  5, 31,  1, 3, 0, 2, 'h1B,        1, 5,           0, 0};
    tbl[8]  = '{1, 1, 6, 6,           1, 0,  6,  2,  0, 4, 0, 2, 'h1B,        1, 6,           0, 0};
    tbl[9]  = '{1, 1, 9, 9,           1, 0,  9,  3,  0, 4, 0, 2, 'h1B,        0, 0,           1, 3};
    tbl[10] = '{1, 1, 9, 9,           0, 0,  3,  4,  1, 3, 1, 3, 3,           1, 3,           1, 4};
    tbl[11] = '{1, 1, 9, 9,           0, 0,  9,  4,  1, 3, 1, 4, 4,           1, 9,           1, 4};
    tbl[12] = '{0, 0, 0, 0,           0, 0,  6, 31,  1, 2, 1, 5, 5,           1, 6,           0, 0};
    tbl[13] = '{0, 0, 0, 0,           0, 0,  9, 31,  1, 1, 1, 6, 6,           1, 9,           0, 0};
    tbl[14] = '{0, 0, 0, 0,           0, 0,  9,  6,  1, 0, 1, 9, 9,           1, 9,           0, 0};
    tbl[15] = '{0, 0, 0, 0,           0, 0,  9, 31,  1, 0, 0, 9, 9,           0, 0,           0, 0};
    tbl[16] = '{1, 1, 6, 'hF00FF000,  1, 0,  6,  7,  1, 1, 0, 9, 9,           1, 'hF00FF000,  0, 0};
    tbl[17] = '{1, 1, 6, 'h0FF00000,  1, 0,  6,  7,  1, 2, 0, 9, 9,           1, 'h0FF00000,  0, 0};
    tbl[18] = '{0, 0, 0, 0,           1, 0,  6,  9,  1, 2, 0, 9, 9,           1, 'h0FF00000,  0, 0};
    tbl[19] = '{1, 1, 7, 'h77,        1, 0,  7,  6,  1, 3, 0, 9, 9,           1, 'h77,        1, 'h0FF00000};
    tbl[20] = '{1, 1, 8, 'h88,        1, 1,  6,  8,  1, 0, 0, 9, 9,           0, 0,           0, 0};
    tbl[21] = '{0, 0, 0, 0,           0, 0,  6,  7,  1, 0, 0, 9, 9,           0, 0,           0, 0};
    tbl[22] = '{0, 0, 0, 0,           0, 0,  6,  7,  1, 0, 0, 9, 9,           0, 0,           0, 0};
    tbl[23] = '{1, 1, 0, 'hAAAA,      0, 0,  0, 31,  1, 1, 0, 9, 9,           1, 'hAAAA,      0, 0};
    tbl[24] = '{0, 0, 0, 0,           0, 0,  0, 31,  1, 0, 1, 0, 'hAAAA,      1, 'hAAAA,      0, 0};
    tbl[25] = '{0, 0, 0, 0,           0, 0,  0, 31,  1, 0, 0, 0, 'hAAAA,      0, 0,           0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    fwd_rs1_addr = '0;
    fwd_rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ready", 32'(ex_ready), 32'd1);
    check_fwd("rst_fwd", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].fl);
      fwd_rs1_addr = ADDR_W'(tbl[i].rs1);
      fwd_rs2_addr = ADDR_W'(tbl[i].rs2);
      @(posedge clk);
      #1;
      check($sformatf("r%0d_ready", i), 32'(ex_ready), 32'(tbl[i].rdy));
      check($sformatf("r%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
      check($sformatf("r%0d_wb_en", i), 32'(wb_en), 32'(tbl[i].en));
      check($sformatf("r%0d_wb_addr", i), 32'(wb_addr), 32'(tbl[i].wa));
      check($sformatf("r%0d_wb_data", i), wb_data, tbl[i].wd);
      check_fwd($sformatf("r%0d_fwd", i), tbl[i].h1, tbl[i].d1, tbl[i].h2, tbl[i].d2);
    end

    // Reset in the middle of a drain, then normal traffic afterwards.
    fwd_rs1_addr = ADDR_W'(20);
    fwd_rs2_addr = ADDR_W'(21);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 20 + k, 'h20 + k, 1, 0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("mid_wb_en", 32'(wb_en), 32'd1);
    check("mid_wb_addr", 32'(wb_addr), 32'd20);
    check("mid_pending", 32'(pending), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wb_en", 32'(wb_en), 32'd0);
    check("arst_wb_addr", 32'(wb_addr), 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_ready", 32'(ex_ready), 32'd1);
    check_fwd("arst_fwd", 0, 0, 0, 0);
    #3;
    rst = 1'b0;

    drive(1, 1, 12, 'hC, 0, 0);
    @(posedge clk);
    #1;
    check("post_p1_pending", 32'(pending), 32'd1);
    check("post_p1_wb_en", 32'(wb_en), 32'd0);
    drive(1, 1, 13, 'hD, 0, 0);
    @(posedge clk);
    #1;
    check("post_p2_wb_en", 32'(wb_en), 32'd1);
    check("post_p2_wb_addr", 32'(wb_addr), 32'd12);
    check("post_p2_wb_data", wb_data, 32'hC);
    check("post_p2_pending", 32'(pending), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("post_p3_wb_en", 32'(wb_en), 32'd1);
    check("post_p3_wb_addr", 32'(wb_addr), 32'd13);
    check("post_p3_wb_data", wb_data, 32'hD);
    check("post_p3_pending", 32'(pending), 32'd0);
    @(posedge clk);
    #1;
    check("post_p4_wb_en", 32'(wb_en), 32'd0);
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
